// File: rtl/mbr_pkg.sv
// Shared types and default sizes for the memory buffer register controller.
package mbr_pkg;

   localparam int unsigned MBR_DATA_W = 8;
   localparam int unsigned MBR_ADDR_W = 4;
   localparam int unsigned MBR_DEPTH  = 16;
   localparam int unsigned MBR_RD_LAT = 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_RD_LOAD = 2'd2,
      ST_WR      = 2'd3
   } state_e;

endpackage

// File: rtl/mbr_mem_ctrl_if.sv
// CPU-side command/data bus of the MBR controller.
interface mbr_mem_ctrl_if
   import mbr_pkg::*;
#(
   parameter int unsigned DATA_W = MBR_DATA_W,
   parameter int unsigned ADDR_W = MBR_ADDR_W
);
   logic              mbr_in;
   logic              mbr_out;
   logic              mem_rd;
   logic              mem_wr;
   logic [ADDR_W-1:0] pointer;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              busy;
   logic              done;
   logic              addr_err;

   modport master (
      output mbr_in, mbr_out, mem_rd, mem_wr, pointer, data_in,
      input  data_out, busy, done, addr_err
   );

   modport slave (
      input  mbr_in, mbr_out, mem_rd, mem_wr, pointer, data_in,
      output data_out, busy, done, addr_err
   );
endinterface

// File: rtl/mbr_ram.sv
// Single-port synchronous RAM, read-first, with an RD_LAT-stage read pipeline.
// Out-of-range addresses never write and read back as zero.
module mbr_ram
   import mbr_pkg::*;
#(
   parameter int unsigned DATA_W = MBR_DATA_W,
   parameter int unsigned ADDR_W = MBR_ADDR_W,
   parameter int unsigned DEPTH  = MBR_DEPTH,
   parameter int unsigned RD_LAT = MBR_RD_LAT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem  [DEPTH];
   logic [DATA_W-1:0] pipe [RD_LAT];
   logic              in_range_c;
   logic [IDX_W-1:0]  idx_c;
   logic [DATA_W-1:0] rd_word_c;

   assign in_range_c = 32'(addr) < DEPTH;
   assign idx_c      = IDX_W'(addr);
   assign rd_word_c  = in_range_c ? mem[idx_c] : '0;
   assign rdata      = pipe[RD_LAT-1];

   // Storage array; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we && in_range_c) mem[idx_c] <= wdata;
   end

   // Read pipeline; stage 0 samples the array before any same-edge write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(RD_LAT); i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= rd_word_c;
         for (int i = 1; i < int'(RD_LAT); i++) pipe[i] <= pipe[i-1];
      end
   end
endmodule

// File: rtl/mbr_mem_ctrl.sv
// Memory buffer register with local RAM, command sequencing and busy/done handshake.
module mbr_mem_ctrl
   import mbr_pkg::*;
#(
   parameter int unsigned DATA_W = MBR_DATA_W,
   parameter int unsigned ADDR_W = MBR_ADDR_W,
   parameter int unsigned DEPTH  = MBR_DEPTH,
   parameter int unsigned RD_LAT = MBR_RD_LAT
) (
   input  logic           clk,
   input  logic           rst_n,
   mbr_mem_ctrl_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] mbr_q, wdata_q, data_out_q, ram_rdata;
   logic              ready_q, busy_q, done_q, addr_err_q;
   logic              cmd_ok_c, in_range_c, ram_we_c;
   logic              take_rd_c, take_wr_c, take_ld_c, take_out_c;
   logic              busy_d, done_d, addr_err_d;
   logic [ADDR_W-1:0] ram_addr_c;

   assign cmd_ok_c   = (state_q == ST_IDLE) && ready_q;
   assign in_range_c = 32'(addr_q) < DEPTH;
   assign ram_addr_c = (state_q == ST_IDLE) ? bus.pointer : addr_q;

   assign bus.data_out = data_out_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.addr_err = addr_err_q;

   mbr_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .RD_LAT (RD_LAT)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (ram_we_c),
      .addr  (ram_addr_c),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; a read outranks a write, a write outranks a load.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_ok_c && bus.mem_rd)      state_d = ST_RD_WAIT;
            else if (cmd_ok_c && bus.mem_wr) state_d = ST_WR;
         end
         ST_RD_WAIT: if (cnt_q == CNT_W'(1)) state_d = ST_RD_LOAD;
         ST_RD_LOAD: state_d = ST_IDLE;
         ST_WR:      state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Command decode and next values of the registered outputs.
   always_comb begin
      take_rd_c  = cmd_ok_c && bus.mem_rd;
      take_wr_c  = cmd_ok_c && !bus.mem_rd && bus.mem_wr;
      take_ld_c  = cmd_ok_c && !bus.mem_rd && !bus.mem_wr && bus.mbr_in;
      take_out_c = cmd_ok_c && bus.mbr_out;
      busy_d     = (state_d != ST_IDLE);
      done_d     = 1'b0;
      ram_we_c   = 1'b0;
      case (state_q)
         ST_RD_LOAD: done_d = 1'b1;
         ST_WR: begin
            done_d   = 1'b1;
            ram_we_c = 1'b1;
         end
         default: ;
      endcase
      addr_err_d = done_d && !in_range_c;
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         addr_err_q <= 1'b0;
         data_out_q <= '0;
         mbr_q      <= '0;
         wdata_q    <= '0;
         addr_q     <= '0;
         cnt_q      <= '0;
      end else begin
         ready_q    <= 1'b1;
         busy_q     <= busy_d;
         done_q     <= done_d;
         addr_err_q <= addr_err_d;
         if (take_out_c) data_out_q <= mbr_q;
         if (take_rd_c || take_wr_c) addr_q <= bus.pointer;
         if (take_wr_c) wdata_q <= mbr_q;
         if (take_rd_c)                  cnt_q <= CNT_W'(RD_LAT);
         else if (state_q == ST_RD_WAIT) cnt_q <= cnt_q - CNT_W'(1);
         if (take_ld_c)                  mbr_q <= bus.data_in;
         else if (state_q == ST_RD_LOAD) mbr_q <= ram_rdata;
      end
   end
endmodule

// File: tb/tb_mbr_mem_ctrl.sv
// Bench for mbr_mem_ctrl: two configurations driven in lockstep, scoreboard of expected results.
module tb_mbr_mem_ctrl;
   import mbr_pkg::*;

   localparam int LAT0 = 1;
   localparam int LAT1 = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic       rd = 1'b0, wr = 1'b0, ld = 1'b0, out = 1'b0;
   logic [3:0] ptr = 4'h0;
   logic [7:0] din = 8'h00;

   mbr_mem_ctrl_if #(.DATA_W(8), .ADDR_W(4)) if0 ();
   mbr_mem_ctrl_if #(.DATA_W(8), .ADDR_W(4)) if1 ();

   assign if0.mem_rd = rd;  assign if1.mem_rd = rd;
   assign if0.mem_wr = wr;  assign if1.mem_wr = wr;
   assign if0.mbr_in = ld;  assign if1.mbr_in = ld;
   assign if0.mbr_out = out; assign if1.mbr_out = out;
   assign if0.pointer = ptr; assign if1.pointer = ptr;
   assign if0.data_in = din; assign if1.data_in = din;

   mbr_mem_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .RD_LAT(LAT0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0.slave));
   mbr_mem_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .RD_LAT(LAT1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1.slave));

   logic [7:0] dout [2];
   logic       busy [2], done [2], aerr [2];
   assign dout[0] = if0.data_out; assign dout[1] = if1.data_out;
   assign busy[0] = if0.busy;     assign busy[1] = if1.busy;
   assign done[0] = if0.done;     assign done[1] = if1.done;
   assign aerr[0] = if0.addr_err; assign aerr[1] = if1.addr_err;

   int checks = 0;
   int errors = 0;

   typedef struct { int lat; bit aerr; } done_exp_t;
   done_exp_t  done_q [$];
   logic [7:0] data_q [$];

   int c_lat [2], c_cnt [2], c_stray [2];
   bit c_aerr [2];

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clr();
      rd = 1'b0; wr = 1'b0; ld = 1'b0; out = 1'b0;
   endtask

   task automatic pulse(input bit r, input bit w, input bit l, input bit o,
                        input logic [3:0] p, input logic [7:0] d);
      rd = r; wr = w; ld = l; out = o; ptr = p; din = d;
      tick();
      clr();
   endtask

   // Watch n cycles after a command edge; latency counts the command cycle as 1.
   task automatic collect(input int n);
      for (int d = 0; d < 2; d++) begin
         c_lat[d] = 0; c_cnt[d] = 0; c_aerr[d] = 1'b0; c_stray[d] = 0;
      end
      for (int k = 2; k < n + 2; k++) begin
         tick();
         clr();
         for (int d = 0; d < 2; d++) begin
            if (done[d]) begin
               c_cnt[d]++;
               if (c_lat[d] == 0) begin c_lat[d] = k; c_aerr[d] = aerr[d]; end
            end else if (aerr[d]) c_stray[d]++;
         end
      end
   endtask

   task automatic push_done(input int l0, input bit a0, input int l1, input bit a1);
      done_exp_t e;
      e.lat = l0; e.aerr = a0; done_q.push_back(e);
      e.lat = l1; e.aerr = a1; done_q.push_back(e);
   endtask

   task automatic push_data(input logic [7:0] d0, input logic [7:0] d1);
      data_q.push_back(d0);
      data_q.push_back(d1);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (dout[d] !== 8'h00 || busy[d] !== 1'b0 || done[d] !== 1'b0 || aerr[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset dut%0d got dout=%h busy=%b done=%b aerr=%b expected all 0",
                     d, dout[d], busy[d], done[d], aerr[d]);
         end
      end
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick();
   endtask

   task automatic test_load_out();
      pulse(0, 0, 1, 0, 4'h0, 8'hAA);
      push_data(8'hAA, 8'hAA);
      pulse(0, 0, 0, 1, 4'h0, 8'h00);
      for (int d = 0; d < 2; d++) begin
         logic [7:0] ed;
         ed = data_q.pop_front();
         checks++;
         if (dout[d] !== ed || busy[d] !== 1'b0) begin
            errors++;
            $display("FAIL load_out dut%0d got dout=%h busy=%b expected dout=%h busy=0",
                     d, dout[d], busy[d], ed);
         end
      end
   endtask

   task automatic test_wr_rd();
      pulse(0, 0, 1, 0, 4'h0, 8'h5C);
      pulse(0, 1, 0, 0, 4'h3, 8'h00);
      push_done(2, 1'b0, 2, 1'b0);
      collect(8);
      pulse(0, 0, 1, 0, 4'h0, 8'h00);
      pulse(1, 0, 0, 0, 4'h3, 8'h00);
      push_done(LAT0 + 2, 1'b0, LAT1 + 2, 1'b0);
      push_data(8'h5C, 8'h5C);
      begin
         int c_lat_w [2], c_cnt_w [2];
         // collect() already ran for the write before the read was issued, so re-derive from two windows
         c_lat_w = c_lat; c_cnt_w = c_cnt;
         collect(8);
         for (int d = 0; d < 2; d++) begin
            done_exp_t e;
            e = done_q.pop_front();
            checks++;
            if (c_lat_w[d] !== e.lat || c_cnt_w[d] !== 1) begin
               errors++;
               $display("FAIL wr_done dut%0d got lat=%0d cnt=%0d expected lat=%0d cnt=1",
                        d, c_lat_w[d], c_cnt_w[d], e.lat);
            end
         end
      end
      for (int d = 0; d < 2; d++) begin
         done_exp_t e;
         e = done_q.pop_front();
         checks++;
         if (c_lat[d] !== e.lat || c_cnt[d] !== 1 || c_aerr[d] !== e.aerr || c_stray[d] !== 0) begin
            errors++;
            $display("FAIL rd_done dut%0d got lat=%0d cnt=%0d aerr=%b stray=%0d expected lat=%0d cnt=1 aerr=%b",
                     d, c_lat[d], c_cnt[d], c_aerr[d], c_stray[d], e.lat, e.aerr);
         end
      end
      pulse(0, 0, 0, 1, 4'h0, 8'h00);
      for (int d = 0; d < 2; d++) begin
         logic [7:0] ed;
         ed = data_q.pop_front();
         checks++;
         if (dout[d] !== ed) begin
            errors++;
            $display("FAIL wr_rd_data dut%0d got %h expected %h", d, dout[d], ed);
         end
      end
   endtask

   task automatic test_priority();
      pulse(0, 0, 1, 0, 4'h0, 8'h3C);
      pulse(0, 1, 0, 0, 4'h5, 8'h00);
      collect(4);
      pulse(0, 0, 1, 0, 4'h0, 8'h99);
      pulse(1, 1, 1, 0, 4'h5, 8'h77);
      push_done(LAT0 + 2, 1'b0, LAT1 + 2, 1'b0);
      collect(8);
      for (int d = 0; d < 2; d++) begin
         done_exp_t e;
         e = done_q.pop_front();
         checks++;
         if (c_lat[d] !== e.lat || c_cnt[d] !== 1) begin
            errors++;
            $display("FAIL prio_done dut%0d got lat=%0d cnt=%0d expected lat=%0d cnt=1",
                     d, c_lat[d], c_cnt[d], e.lat);
         end
      end
      push_data(8'h3C, 8'h3C);
      pulse(0, 0, 0, 1, 4'h0, 8'h00);
      for (int d = 0; d < 2; d++) begin
         logic [7:0] ed;
         ed = data_q.pop_front();
         checks++;
         if (dout[d] !== ed) begin
            errors++;
            $display("FAIL prio_mbr dut%0d got %h expected %h", d, dout[d], ed);
         end
      end
      pulse(0, 0, 1, 0, 4'h0, 8'h00);
      pulse(1, 0, 0, 0, 4'h5, 8'h00);
      collect(8);
      push_data(8'h3C, 8'h3C);
      pulse(0, 0, 0, 1, 4'h0, 8'h00);
      for (int d = 0; d < 2; d++) begin
         logic [7:0] ed;
         ed = data_q.pop_front();
         checks++;
         if (dout[d] !== ed) begin
            errors++;
            $display("FAIL prio_ram dut%0d got %h expected %h", d, dout[d], ed);
         end
      end
   endtask

   task automatic test_busy_ignore();
      pulse(0, 0, 1, 0, 4'h0, 8'h42);
      pulse(0, 1, 0, 0, 4'h7, 8'h00);
      collect(4);
      pulse(0, 0, 1, 0, 4'h0, 8'hE1);
      wr = 1'b1; ptr = 4'h2;
      tick();
      ptr = 4'h7; din = 8'h00;
      push_done(2, 1'b0, 2, 1'b0);
      collect(6);
      for (int d = 0; d < 2; d++) begin
         done_exp_t e;
         e = done_q.pop_front();
         checks++;
         if (c_lat[d] !== e.lat || c_cnt[d] !== 1) begin
            errors++;
            $display("FAIL busy_done dut%0d got lat=%0d cnt=%0d expected lat=%0d cnt=1",
                     d, c_lat[d], c_cnt[d], e.lat);
         end
      end
      pulse(1, 0, 0, 0, 4'h7, 8'h00);
      collect(8);
      push_data(8'h42, 8'h42);
      pulse(0, 0, 0, 1, 4'h0, 8'h00);
      for (int d = 0; d < 2; d++) begin
         logic [7:0] ed;
         ed = data_q.pop_front();
         checks++;
         if (dout[d] !== ed) begin
            errors++;
            $display("FAIL busy_ram7 dut%0d got %h expected %h", d, dout[d], ed);
         end
      end
   endtask

   task automatic test_out_of_range();
      pulse(0, 0, 1, 0, 4'h0, 8'h6D);
      pulse(0, 1, 0, 0, 4'hE, 8'h00);
      push_done(2, 1'b0, 2, 1'b1);
      collect(4);
      for (int d = 0; d < 2; d++) begin
         done_exp_t e;
         e = done_q.pop_front();
         checks++;
         if (c_lat[d] !== e.lat || c_cnt[d] !== 1 || c_aerr[d] !== e.aerr || c_stray[d] !== 0) begin
            errors++;
            $display("FAIL oor_wr dut%0d got lat=%0d cnt=%0d aerr=%b stray=%0d expected lat=%0d cnt=1 aerr=%b",
                     d, c_lat[d], c_cnt[d], c_aerr[d], c_stray[d], e.lat, e.aerr);
         end
      end
      pulse(0, 0, 1, 0, 4'h0, 8'hFF);
      pulse(1, 0, 0, 0, 4'hE, 8'h00);
      push_done(LAT0 + 2, 1'b0, LAT1 + 2, 1'b1);
      push_data(8'h6D, 8'h00);
      collect(8);
      for (int d = 0; d < 2; d++) begin
         done_exp_t e;
         e = done_q.pop_front();
         checks++;
         if (c_lat[d] !== e.lat || c_cnt[d] !== 1 || c_aerr[d] !== e.aerr || c_stray[d] !== 0) begin
            errors++;
            $display("FAIL oor_rd dut%0d got lat=%0d cnt=%0d aerr=%b stray=%0d expected lat=%0d cnt=1 aerr=%b",
                     d, c_lat[d], c_cnt[d], c_aerr[d], c_stray[d], e.lat, e.aerr);
         end
      end
      pulse(0, 0, 0, 1, 4'h0, 8'h00);
      for (int d = 0; d < 2; d++) begin
         logic [7:0] ed;
         ed = data_q.pop_front();
         checks++;
         if (dout[d] !== ed) begin
            errors++;
            $display("FAIL oor_data dut%0d got %h expected %h", d, dout[d], ed);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      int dn [2];
      pulse(0, 0, 1, 0, 4'h0, 8'h33);
      pulse(0, 1, 0, 0, 4'h9, 8'h00);
      collect(4);
      pulse(0, 0, 1, 0, 4'h0, 8'h5A);
      pulse(0, 0, 0, 1, 4'h0, 8'h00);
      pulse(1, 0, 0, 0, 4'h3, 8'h00);
      tick();
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (dout[d] !== 8'h00 || busy[d] !== 1'b0 || done[d] !== 1'b0 || aerr[d] !== 1'b0) begin
            errors++;
            $display("FAIL midrst dut%0d got dout=%h busy=%b done=%b aerr=%b expected all 0",
                     d, dout[d], busy[d], done[d], aerr[d]);
         end
      end
      dn[0] = 0; dn[1] = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         for (int d = 0; d < 2; d++) if (done[d] !== 1'b0) dn[d]++;
      end
      rst_n = 1'b1;
      ld = 1'b1; din = 8'h22;
      tick();
      clr();
      for (int k = 0; k < 5; k++) begin
         tick();
         for (int d = 0; d < 2; d++) if (done[d] !== 1'b0) dn[d]++;
      end
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (dn[d] !== 0) begin
            errors++;
            $display("FAIL midrst_done dut%0d got %0d done pulses expected 0", d, dn[d]);
         end
      end
      push_data(8'h00, 8'h00);
      pulse(0, 0, 0, 1, 4'h0, 8'h00);
      for (int d = 0; d < 2; d++) begin
         logic [7:0] ed;
         ed = data_q.pop_front();
         checks++;
         if (dout[d] !== ed) begin
            errors++;
            $display("FAIL release_gate dut%0d got %h expected %h", d, dout[d], ed);
         end
      end
      pulse(0, 0, 1, 0, 4'h0, 8'h77);
      pulse(0, 1, 0, 0, 4'h9, 8'h00);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick(); tick();
      pulse(1, 0, 0, 0, 4'h9, 8'h00);
      collect(8);
      push_data(8'h33, 8'h33);
      pulse(0, 0, 0, 1, 4'h0, 8'h00);
      for (int d = 0; d < 2; d++) begin
         logic [7:0] ed;
         ed = data_q.pop_front();
         checks++;
         if (dout[d] !== ed) begin
            errors++;
            $display("FAIL wr_abort dut%0d got %h expected %h", d, dout[d], ed);
         end
      end
      pulse(0, 0, 1, 0, 4'h0, 8'h11);
      push_data(8'h11, 8'h11);
      pulse(0, 0, 0, 1, 4'h0, 8'h00);
      for (int d = 0; d < 2; d++) begin
         logic [7:0] ed;
         ed = data_q.pop_front();
         checks++;
         if (dout[d] !== ed) begin
            errors++;
            $display("FAIL post_reset dut%0d got %h expected %h", d, dout[d], ed);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_out();
      test_wr_rd();
      test_priority();
      test_busy_ignore();
      test_out_of_range();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish within 200000 time units");
      $fatal(1);
   end
endmodule
